// File: rtl/cache_ctrl_wt_param.sv
// Write-through, no-write-allocate, direct-mapped cache controller with an internal tag/valid store.
// Define CACHE_CTRL_PERF_EN to add saturating read_hits / read_misses counters.
module cache_ctrl_wt_param #(
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [TAG_W-1:0]   cpu_tag,
  input  logic [INDEX_W-1:0] cpu_index,
  input  logic               invalidate,
  input  logic               mem_ready,
  output logic               stall,
  output logic               hit,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic               fill,
  output logic               update,
`ifdef CACHE_CTRL_PERF_EN
  output logic [CNT_W-1:0]   read_hits,
  output logic [CNT_W-1:0]   read_misses,
`endif
  output logic               flush_busy
);
  localparam int LINES = 2 ** INDEX_W;
  localparam logic [INDEX_W-1:0] LAST_LINE = INDEX_W'(LINES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    FLUSH = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               pend_q, pend_d;
  logic [INDEX_W-1:0] fcnt_q, fcnt_d;
  logic [TAG_W-1:0]   ltag_q, ltag_d;
  logic [INDEX_W-1:0] lidx_q, lidx_d;
  logic               lhit_q, lhit_d;
  logic [TAG_W-1:0]   tag_mem [LINES];
  logic               tag_we;
  logic               inv_any;

  assign inv_any = invalidate || pend_q;
  assign hit     = valid_q[cpu_index] && (tag_mem[cpu_index] == cpu_tag);
  // Tags are never reset; an aborted fill must not leave a stale tag behind either.
  assign tag_we  = rst && (state_q == READ) && mem_ready;

  always_ff @(negedge clk) begin
    if (tag_we) begin
      tag_mem[lidx_q] <= ltag_q;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      pend_q  <= 1'b0;
      fcnt_q  <= '0;
      ltag_q  <= '0;
      lidx_q  <= '0;
      lhit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
      ltag_q  <= ltag_d;
      lidx_q  <= lidx_d;
      lhit_q  <= lhit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    fcnt_d  = fcnt_q;
    ltag_d  = ltag_q;
    lidx_d  = lidx_q;
    lhit_d  = lhit_q;
    case (state_q)
      IDLE: begin
        // A sweep wins over any request; a simultaneous read+write is a write.
        if (inv_any) begin
          state_d = FLUSH;
          pend_d  = 1'b0;
          fcnt_d  = '0;
        end else if (cpu_write) begin
          state_d = WRITE;
          ltag_d  = cpu_tag;
          lidx_d  = cpu_index;
          lhit_d  = hit;
        end else if (cpu_read && !hit) begin
          state_d = READ;
          ltag_d  = cpu_tag;
          lidx_d  = cpu_index;
          lhit_d  = 1'b0;
        end
      end
      READ: begin
        pend_d = pend_q | invalidate;
        if (mem_ready) begin
          valid_d[lidx_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      WRITE: begin
        pend_d = pend_q | invalidate;
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        pend_d          = pend_q | invalidate;
        valid_d[fcnt_q] = 1'b0;
        fcnt_d          = fcnt_q + 1'b1;
        if (fcnt_q == LAST_LINE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall        = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    fill         = 1'b0;
    update       = 1'b0;
    flush_busy   = 1'b0;
    case (state_q)
      IDLE: stall = (cpu_read || cpu_write) && (inv_any || cpu_write || !hit);
      READ: begin
        mem_read_en = 1'b1;
        stall       = !mem_ready;
        fill        = mem_ready;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        stall        = !mem_ready;
        update       = mem_ready && lhit_q;
      end
      FLUSH: begin
        stall      = 1'b1;
        flush_busy = 1'b1;
      end
      default: stall = 1'b0;
    endcase
  end

`ifdef CACHE_CTRL_PERF_EN
  logic [CNT_W-1:0] hits_q, hits_d, miss_q, miss_d;
  logic             rd_idle;

  assign rd_idle     = (state_q == IDLE) && !inv_any && cpu_read && !cpu_write;
  assign read_hits   = hits_q;
  assign read_misses = miss_q;

  always_comb begin
    hits_d = hits_q;
    miss_d = miss_q;
    if (rd_idle && hit && (hits_q != '1)) begin
      hits_d = hits_q + 1'b1;
    end
    if (rd_idle && !hit && (miss_q != '1)) begin
      miss_d = miss_q + 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      hits_q <= '0;
      miss_q <= '0;
    end else begin
      hits_q <= hits_d;
      miss_q <= miss_d;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_wt_param.sv
// Self-checking bench for cache_ctrl_wt_param: directed scenarios followed by random traffic
// checked cycle by cycle against a transaction-level cache model.
module tb_cache_ctrl_wt_param;
  localparam int TW    = 3;
  localparam int IW    = 2;
  localparam int CW    = 4;
  localparam int LINES = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          cpu_read;
  logic          cpu_write;
  logic [TW-1:0] cpu_tag;
  logic [IW-1:0] cpu_index;
  logic          invalidate;
  logic          mem_ready;
  logic          stall;
  logic          hit;
  logic          mem_read_en;
  logic          mem_write_en;
  logic          fill;
  logic          update;
  logic          flush_busy;
`ifdef CACHE_CTRL_PERF_EN
  logic [CW-1:0] read_hits;
  logic [CW-1:0] read_misses;
`endif

  cache_ctrl_wt_param #(.TAG_W(TW), .INDEX_W(IW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .cpu_tag      (cpu_tag),
    .cpu_index    (cpu_index),
    .invalidate   (invalidate),
    .mem_ready    (mem_ready),
    .stall        (stall),
    .hit          (hit),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .fill         (fill),
    .update       (update),
`ifdef CACHE_CTRL_PERF_EN
    .read_hits    (read_hits),
    .read_misses  (read_misses),
`endif
    .flush_busy   (flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cache contents and bookkeeping at transaction level.
  logic          valid_m [LINES];
  logic [TW-1:0] tag_m   [LINES];
  bit            pend_m;
  int            hits_m, misses_m;
  int            errors, checks, txn;

  function automatic logic mhit(input logic [TW-1:0] t, input logic [IW-1:0] i);
    return valid_m[i] && (tag_m[i] == t);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LINES; k++) valid_m[k] = 1'b0;
    pend_m   = 1'b0;
    hits_m   = 0;
    misses_m = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_out(input string n, input logic s, input logic h, input logic mr,
                         input logic mw, input logic f, input logic u, input logic fb);
    chk($sformatf("%s.stall", n),        32'(stall),        32'(s));
    chk($sformatf("%s.hit", n),          32'(hit),          32'(h));
    chk($sformatf("%s.mem_read_en", n),  32'(mem_read_en),  32'(mr));
    chk($sformatf("%s.mem_write_en", n), 32'(mem_write_en), 32'(mw));
    chk($sformatf("%s.fill", n),         32'(fill),         32'(f));
    chk($sformatf("%s.update", n),       32'(update),       32'(u));
    chk($sformatf("%s.flush_busy", n),   32'(flush_busy),   32'(fb));
  endtask

  // Inputs change just after the rising edge; the DUT updates on the falling edge.
  task automatic cyc(input logic r, input logic w, input logic [TW-1:0] t, input logic [IW-1:0] i,
                     input logic inv, input logic mr, input logic rs);
    @(posedge clk);
    cpu_read   = r;
    cpu_write  = w;
    cpu_tag    = t;
    cpu_index  = i;
    invalidate = inv;
    mem_ready  = mr;
    rst        = rs;
    #1;
  endtask

  task automatic bump(inout int c);
    if (c != MAXC) c++;
  endtask

  task automatic do_idle(input logic [TW-1:0] t, input logic [IW-1:0] i);
    cyc(1'b0, 1'b0, t, i, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    chk_out("idle", 1'b0, mhit(t, i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CACHE_CTRL_PERF_EN
    chk("read_hits", 32'(read_hits), 32'(hits_m));
    chk("read_misses", 32'(read_misses), 32'(misses_m));
`endif
    txn++;
    $display("txn %0d: idle idx=%0d tag=%0d", txn, i, t);
  endtask

  task automatic do_read(input logic [TW-1:0] t, input logic [IW-1:0] i, input int dly, input int inv_k);
    logic eh;
    eh = mhit(t, i);
    cyc(1'b1, 1'b0, t, i, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    chk_out("rd_accept", !eh, eh, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (eh) begin
      bump(hits_m);
    end else begin
      bump(misses_m);
      for (int k = 0; k <= dly; k++) begin
        cyc(1'b1, 1'b0, t, i, 1'(k == inv_k), 1'(k == dly), 1'b1);
        chk_out("rd_mem", 1'(k != dly), eh, 1'b1, 1'b0, 1'(k == dly), 1'b0, 1'b0);
        if (k == inv_k) pend_m = 1'b1;
      end
      valid_m[i] = 1'b1;
      tag_m[i]   = t;
    end
    txn++;
    $display("txn %0d: read idx=%0d tag=%0d hit=%0d dly=%0d inv_at=%0d", txn, i, t, eh, dly, inv_k);
  endtask

  task automatic do_write(input logic [TW-1:0] t, input logic [IW-1:0] i, input int dly,
                          input int inv_k, input logic both);
    logic eh;
    eh = mhit(t, i);
    cyc(both, 1'b1, t, i, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    chk_out("wr_accept", 1'b1, eh, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= dly; k++) begin
      cyc(both, 1'b1, t, i, 1'(k == inv_k), 1'(k == dly), 1'b1);
      chk_out("wr_mem", 1'(k != dly), eh, 1'b0, 1'b1, 1'b0, 1'((k == dly) && eh), 1'b0);
      if (k == inv_k) pend_m = 1'b1;
    end
    txn++;
    $display("txn %0d: write idx=%0d tag=%0d hit=%0d both=%0d dly=%0d", txn, i, t, eh, both, dly);
  endtask

  // One IDLE cycle that launches the sweep, then one cycle per line.
  task automatic do_flush(input logic with_inv, input logic rq, input logic allow_inv);
    logic [TW-1:0] t;
    logic [IW-1:0] i;
    logic          inv_now;
    t = 3'($urandom_range(0, 7));
    i = 2'($urandom_range(0, 3));
    cyc(rq, 1'b0, t, i, with_inv, 1'($urandom_range(0, 1)), 1'b1);
    chk_out("fl_start", rq, mhit(t, i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pend_m = 1'b0;
    for (int k = 0; k < LINES; k++) begin
      inv_now = allow_inv && ($urandom_range(0, 7) == 0);
      cyc(rq, 1'b0, t, i, inv_now, 1'($urandom_range(0, 1)), 1'b1);
      chk_out("flush", 1'b1, mhit(t, i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      valid_m[k] = 1'b0;
      if (inv_now) pend_m = 1'b1;
    end
    txn++;
    $display("txn %0d: flush req=%0d pending_after=%0d", txn, rq, pend_m);
  endtask

  logic [TW-1:0] rt;
  logic [IW-1:0] ri;
  int            rd, rk;

  initial begin
    errors = 0;
    checks = 0;
    txn    = 0;
    for (int k = 0; k < LINES; k++) tag_m[k] = '0;
    cpu_read = 0; cpu_write = 0; cpu_tag = 0; cpu_index = 0;
    invalidate = 0; mem_ready = 0; rst = 0;

    // T1: reset held for two edges
    cyc(1'b1, 1'b0, 3'd5, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 3'd5, 2'd1, 1'b0, 1'b0, 1'b0);
    model_reset();
    do_idle(3'd5, 2'd1);

    // T2: read miss with a 3-cycle memory delay, then a hit
    do_read(3'd5, 2'd1, 3, -1);
    do_read(3'd5, 2'd1, 0, -1);

    // T3: write hit updates; write miss does not allocate
    do_write(3'd5, 2'd1, 1, -1, 1'b0);
    do_write(3'd3, 2'd2, 0, -1, 1'b0);
    do_read(3'd3, 2'd2, 1, -1);

    // T4: invalidate during a read completes the fill, then sweeps
    do_read(3'd2, 2'd3, 2, 1);
    do_flush(1'b0, 1'b1, 1'b0);
    do_read(3'd5, 2'd1, 0, -1);
    do_idle(3'd5, 2'd1);

    // T5: reset mid-write aborts the transaction
    cyc(1'b0, 1'b1, 3'd5, 2'd1, 1'b0, 1'b0, 1'b1);
    chk_out("t5_accept", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'd5, 2'd1, 1'b0, 1'b0, 1'b1);
    chk_out("t5_wait", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'd5, 2'd1, 1'b0, 1'b0, 1'b0);
    model_reset();
    do_idle(3'd5, 2'd1);
    $display("txn %0d: reset during write", txn);

    // T6: three hits, two misses, then drive the hit counter into saturation
    do_read(3'd5, 2'd1, 0, -1);
    do_read(3'd5, 2'd1, 0, -1);
    do_read(3'd5, 2'd1, 0, -1);
    do_read(3'd5, 2'd1, 0, -1);
    do_read(3'd1, 2'd2, 1, -1);
    do_idle(3'd0, 2'd0);
    for (int n = 0; n < 20; n++) do_read(3'd5, 2'd1, 0, -1);
    do_idle(3'd5, 2'd1);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      rt = 3'($urandom_range(0, 2));
      ri = 2'($urandom_range(0, 3));
      rd = $urandom_range(0, 3);
      rk = ($urandom_range(0, 5) == 0) ? $urandom_range(0, rd) : -1;
      if (pend_m) begin
        do_flush(1'b0, 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        case ($urandom_range(0, 6))
          0, 1, 2: do_read(rt, ri, rd, rk);
          3, 4:    do_write(rt, ri, rd, rk, 1'($urandom_range(0, 1)));
          5:       do_flush(1'b1, 1'($urandom_range(0, 1)), 1'b1);
          default: do_idle(rt, ri);
        endcase
      end
    end
    while (pend_m) do_flush(1'b0, 1'b0, 1'b0);
    do_idle(3'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
